// File: rtl/vga_bars_peak.sv
// Spectrum-bar VGA renderer (640x480 @ 60 Hz by default) with per-bar peak hold.
// Ports:
//   vgaclk      pixel clock
//   rst         asynchronous active-low reset
//   data        NBARS packed bar heights, bar i at [i*DW +: DW]
//   mode        0 red, 1 red+peak, 2 zoned, 3 zoned+peak
//   hsync/vsync active-low syncs
//   red/green/blue 4-bit colour channels
//   done        high during blanking rows (vc >= V_ACTIVE)
//   frame_start one-cycle pulse for the hc = 0, vc = 0 output cycle
// The raster timing parameters default to the standard 640x480 frame; zone
// boundaries (1/2 and 4/5 of the active height) and the height clamp follow
// V_ACTIVE.
module vga_bars_peak #(
    parameter int unsigned NBARS       = 16,
    parameter int unsigned DW          = 10,
    parameter int unsigned GAP         = 2,
    parameter int unsigned HOLD_FRAMES = 30,
    parameter int unsigned DECAY       = 4,
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33
) (
    input  logic                  vgaclk,
    input  logic                  rst,
    input  logic [NBARS*DW-1:0]   data,
    input  logic [1:0]            mode,
    output logic                  hsync,
    output logic                  vsync,
    output logic [3:0]            red,
    output logic [3:0]            green,
    output logic [3:0]            blue,
    output logic                  done,
    output logic                  frame_start
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = HS_START + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = VS_START + V_SYNC;
    localparam int unsigned HW       = $clog2(H_TOTAL);
    localparam int unsigned VW       = $clog2(V_TOTAL);
    localparam int unsigned BW       = H_ACTIVE / NBARS;
    localparam int unsigned CW       = (BW > 1) ? $clog2(BW) : 1;
    localparam int unsigned BIW      = (NBARS > 1) ? $clog2(NBARS) : 1;
    localparam int unsigned YW       = $clog2(V_ACTIVE + 1);
    localparam int unsigned TW       = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
    localparam int unsigned ZONE_Y   = V_ACTIVE / 2;
    localparam int unsigned ZONE_R   = (V_ACTIVE * 4) / 5;

    logic [HW-1:0]  hc;
    logic [VW-1:0]  vc;
    logic [CW-1:0]  col;
    logic [BIW-1:0] bar;

    logic [YW-1:0]  snap    [NBARS];
    logic [YW-1:0]  peak    [NBARS];
    logic [TW-1:0]  hold    [NBARS];
    logic [YW-1:0]  s_new_c [NBARS];
    logic [YW-1:0]  decay_c [NBARS];

    logic           snap_now_c;
    logic [YW-1:0]  y_c;
    logic           marker_c;
    logic [11:0]    rgb_c;

    // Raster counters
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            hc <= '0;
            vc <= '0;
        end else if (hc == HW'(H_TOTAL - 1)) begin
            hc <= '0;
            vc <= (vc == VW'(V_TOTAL - 1)) ? '0 : vc + VW'(1);
        end else begin
            hc <= hc + HW'(1);
        end
    end

    // Column-in-bar and bar index, tracked incrementally instead of dividing hc
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            col <= '0;
            bar <= '0;
        end else if (hc == HW'(H_TOTAL - 1)) begin
            col <= '0;
            bar <= '0;
        end else if (hc < HW'(H_ACTIVE)) begin
            if (col == CW'(BW - 1)) begin
                col <= '0;
                bar <= (bar == BIW'(NBARS - 1)) ? '0 : bar + BIW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Clamped incoming heights and saturating peak decay candidates
    always_comb begin
        for (int i = 0; i < NBARS; i++) begin
            s_new_c[i] = (32'(data[i*DW +: DW]) > V_ACTIVE) ? YW'(V_ACTIVE)
                                                           : YW'(data[i*DW +: DW]);
            decay_c[i] = (32'(peak[i]) > DECAY) ? peak[i] - YW'(DECAY) : '0;
        end
    end

    assign snap_now_c = (hc == '0) && (vc == VW'(V_ACTIVE));

    // Once-per-frame snapshot at the start of vertical blanking, with peak hold/decay
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NBARS; i++) begin
                snap[i] <= '0;
                peak[i] <= '0;
                hold[i] <= '0;
            end
        end else if (snap_now_c) begin
            for (int i = 0; i < NBARS; i++) begin
                snap[i] <= s_new_c[i];
                if (s_new_c[i] >= peak[i]) begin
                    peak[i] <= s_new_c[i];
                    hold[i] <= TW'(HOLD_FRAMES);
                end else if (hold[i] != '0) begin
                    hold[i] <= hold[i] - TW'(1);
                end else begin
                    peak[i] <= (s_new_c[i] > decay_c[i]) ? s_new_c[i] : decay_c[i];
                end
            end
        end
    end

    // Row measured upward from the bottom of the active area
    assign y_c = YW'(V_ACTIVE - 1) - YW'(vc);

    // Marker occupies the two rows just below the held peak
    assign marker_c = mode[0] && (peak[bar] != '0) &&
                      (({1'b0, y_c} + (YW+1)'(1) == {1'b0, peak[bar]}) ||
                       ({1'b0, y_c} + (YW+1)'(2) == {1'b0, peak[bar]}));

    // Pixel colour for the current hc/vc
    always_comb begin
        rgb_c = 12'h000;
        if ((hc < HW'(H_ACTIVE)) && (vc < VW'(V_ACTIVE)) && (32'(col) < BW - GAP)) begin
            if (marker_c) begin
                rgb_c = 12'hFFF;
            end else if (y_c < snap[bar]) begin
                if (!mode[1])                rgb_c = 12'hF00;
                else if (y_c < YW'(ZONE_Y))  rgb_c = 12'h0F0;
                else if (y_c < YW'(ZONE_R))  rgb_c = 12'hFF0;
                else                         rgb_c = 12'hF00;
            end
        end
    end

    // All outputs registered from the same counter values so they stay aligned
    always_ff @(posedge vgaclk or negedge rst) begin
        if (!rst) begin
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            red         <= '0;
            green       <= '0;
            blue        <= '0;
            done        <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            hsync       <= !((hc >= HW'(HS_START)) && (hc < HW'(HS_END)));
            vsync       <= !((vc >= VW'(VS_START)) && (vc < VW'(VS_END)));
            red         <= rgb_c[11:8];
            green       <= rgb_c[7:4];
            blue        <= rgb_c[3:0];
            done        <= (vc >= VW'(V_ACTIVE));
            frame_start <= (hc == '0) && (vc == '0);
        end
    end

endmodule
